// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer behind the SDF FFT.
// Bit-reversed samples are written at their bin index into one bank.
// The other bank is read out in natural bin order as a gapless stream.
module fft_bitrev_reorder #(
  parameter int N          = 1024,
  parameter int N_LOG2     = 10,
  parameter int DATA_WIDTH = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  sync_i,
  input  logic [N_LOG2-1:0]     ctr_i,
  input  logic [DATA_WIDTH-1:0] data_re_i,
  input  logic [DATA_WIDTH-1:0] data_im_i,
  output logic                  valid_o,
  output logic [N_LOG2-1:0]     bin_o,
  output logic [DATA_WIDTH-1:0] data_re_o,
  output logic [DATA_WIDTH-1:0] data_im_o
);

  localparam int                W         = 2 * DATA_WIDTH;
  localparam logic [N_LOG2:0]   CNT_LAST  = (N_LOG2+1)'(N - 1);
  localparam logic [N_LOG2:0]   CNT_ONE   = (N_LOG2+1)'(1);
  localparam logic [N_LOG2-1:0] ADDR_LAST = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] ADDR_ONE  = N_LOG2'(1);

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_e;

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [W-1:0]        mem [2*N];

  logic                wr_bank_q, wr_bank_d;
  logic [N_LOG2:0]     wr_cnt_q, wr_cnt_d;
  logic                frame_done;

  state_e              state_q, state_d;
  logic [N_LOG2-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en;

  // Stage 1: registered RAM read; stage 2: output register.
  logic [1:0]          vld_pipe_q;
  logic [N_LOG2-1:0]   rd_bin_q;
  logic [W-1:0]        rd_data_q;
  logic [N_LOG2-1:0]   bin_q;
  logic [DATA_WIDTH-1:0] re_q, im_q;

  // Write count / bank swap: a frame completes on its N-th written sample.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    frame_done = sync_i && (wr_cnt_q == CNT_LAST);
    if (sync_i) begin
      if (frame_done) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d  = wr_cnt_q + CNT_ONE;
      end
    end
  end

  // Read engine next state: sweep 0..N-1, chaining straight into the next frame if one just completed.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en     = (state_q == S_READ);
    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          state_d   = S_READ;
          rd_addr_d = '0;
        end
      end
      S_READ: begin
        rd_addr_d = rd_addr_q + ADDR_ONE;
        if (rd_addr_q == ADDR_LAST) begin
          rd_addr_d = '0;
          if (!frame_done) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      vld_pipe_q <= '0;
      rd_bin_q   <= '0;
      bin_q      <= '0;
      re_q       <= '0;
      im_q       <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      vld_pipe_q <= {vld_pipe_q[0], rd_en};
      if (rd_en) rd_bin_q <= rd_addr_q;
      if (vld_pipe_q[0]) begin
        bin_q <= rd_bin_q;
        re_q  <= rd_data_q[W-1:DATA_WIDTH];
        im_q  <= rd_data_q[DATA_WIDTH-1:0];
      end
    end
  end

  // Simple dual-port RAM: write into wr_bank, read from the opposite bank.
  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (sync_i) mem[{wr_bank_q, ctr_i}] <= {data_re_i, data_im_i};
    if (rd_en)  rd_data_q <= mem[{~wr_bank_q, rd_addr_q}];
  end

  assign valid_o   = vld_pipe_q[1];
  assign bin_o     = bin_q;
  assign data_re_o = re_q;
  assign data_im_o = im_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N=16).
// Reference model: each completed frame is copied into a queue of expected
// outputs due at (final write cycle + 2 + bin); outputs hold between valids.
module tb_fft_bitrev_reorder;
  localparam int N = 16, LG = 4, DW = 25;

  logic          clk_i = 1'b0, rst_n = 1'b0, sync_i = 1'b0;
  logic [LG-1:0] ctr_i = '0;
  logic [DW-1:0] data_re_i = '0, data_im_i = '0;
  logic          valid_o;
  logic [LG-1:0] bin_o;
  logic [DW-1:0] data_re_o, data_im_o;

  fft_bitrev_reorder #(.N(N), .N_LOG2(LG), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .sync_i(sync_i), .ctr_i(ctr_i),
    .data_re_i(data_re_i), .data_im_i(data_im_i),
    .valid_o(valid_o), .bin_o(bin_o), .data_re_o(data_re_o), .data_im_o(data_im_o)
  );

  always #5 clk_i = ~clk_i;

  int errs = 0, checks = 0, cyc = 0, wcnt = 0, last_wr_cyc = 0;
  logic [DW-1:0] fr_re [N];
  logic [DW-1:0] fr_im [N];
  typedef struct { int due; logic [LG-1:0] bin; logic [DW-1:0] re; logic [DW-1:0] im; } exp_t;
  exp_t q[$];
  logic          e_v = 1'b0;
  logic [LG-1:0] e_bin = '0;
  logic [DW-1:0] e_re = '0, e_im = '0;

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] x);
    logic [LG-1:0] r;
    for (int i = 0; i < LG; i++) r[i] = x[LG-1-i];
    return r;
  endfunction

  // One clock: drive inputs, advance past the edge, update the reference model.
  task automatic apply(input logic s, input logic [LG-1:0] c, input logic [DW-1:0] re, input logic [DW-1:0] im);
    sync_i = s; ctr_i = c; data_re_i = re; data_im_i = im;
    @(posedge clk_i); #1;
    cyc++;
    if (s) begin
      fr_re[c] = re; fr_im[c] = im; wcnt++;
      if (wcnt == N) begin
        wcnt = 0; last_wr_cyc = cyc;
        for (int k = 0; k < N; k++) q.push_back('{cyc + 2 + k, LG'(k), fr_re[k], fr_im[k]});
      end
    end
    e_v = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_v = 1'b1; e_bin = q[0].bin; e_re = q[0].re; e_im = q[0].im;
      void'(q.pop_front());
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; sync_i = 1'b0; ctr_i = '0; data_re_i = '0; data_im_i = '0;
    @(posedge clk_i); #1;
    cyc++;
    q.delete(); wcnt = 0;
    e_v = 1'b0; e_bin = '0; e_re = '0; e_im = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({valid_o, bin_o, data_re_o, data_im_o} !== {1'b0, LG'(0), DW'(0), DW'(0)}) begin
      errs++; $display("FAIL reset: got v=%b bin=%0d re=%h im=%h, want all zero", valid_o, bin_o, data_re_o, data_im_o);
    end
  endtask

  task automatic test_single();
    int first = -1, nv = 0;
    logic [LG-1:0] c;
    for (int n = 0; n < N + 22; n++) begin
      c = bitrev(LG'(n));
      if (n < N) apply(1'b1, c, DW'(100 + int'(c)), DW'(-int'(c)));
      else       apply(1'b0, '0, '0, '0);
      if (valid_o === 1'b1) begin nv++; if (first < 0) first = cyc; end
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL single cyc=%0d: got v=%b bin=%0d re=%h im=%h, want v=%b bin=%0d re=%h im=%h",
                         cyc, valid_o, bin_o, data_re_o, data_im_o, e_v, e_bin, e_re, e_im);
      end
    end
    checks++;
    if (first - last_wr_cyc !== 2 || nv !== N) begin
      errs++; $display("FAIL single_latency: got latency=%0d count=%0d, want 2 and %0d", first - last_wr_cyc, nv, N);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, maxrun = 0;
    logic [LG-1:0] c;
    for (int n = 0; n < 3*N + 20; n++) begin
      c = bitrev(LG'(n % N));
      if (n < 3*N) apply(1'b1, c, DW'(16*(n/N) + int'(c)), DW'($urandom));
      else         apply(1'b0, '0, '0, '0);
      run = (valid_o === 1'b1) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL b2b cyc=%0d: got v=%b bin=%0d re=%h im=%h, want v=%b bin=%0d re=%h im=%h",
                         cyc, valid_o, bin_o, data_re_o, data_im_o, e_v, e_bin, e_re, e_im);
      end
    end
    checks++;
    if (maxrun !== 3*N) begin
      errs++; $display("FAIL b2b_run: got %0d consecutive valid cycles, want %0d", maxrun, 3*N);
    end
  endtask

  task automatic test_gapped();
    int k = 0;
    for (int n = 0; n < N + 5 + 20; n++) begin
      if ((n < 7) || (n >= 12 && k < N)) begin
        apply(1'b1, bitrev(LG'(k)), DW'($urandom), DW'($urandom)); k++;
      end else apply(1'b0, '0, '0, '0);
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL gapped cyc=%0d: got v=%b bin=%0d re=%h im=%h, want v=%b bin=%0d re=%h im=%h",
                         cyc, valid_o, bin_o, data_re_o, data_im_o, e_v, e_bin, e_re, e_im);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < N; n++) apply(1'b1, bitrev(LG'(n)), DW'($urandom), DW'($urandom));
    for (int i = 0; i < 12 && !(e_v && e_bin == 5); i++) begin
      apply(1'b0, '0, '0, '0);
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL rstmid_pre cyc=%0d: got v=%b bin=%0d re=%h, want v=%b bin=%0d re=%h",
                         cyc, valid_o, bin_o, data_re_o, e_v, e_bin, e_re);
      end
    end
    checks++;
    if (!(e_v && e_bin == 5)) begin errs++; $display("FAIL rstmid_reach: bin 5 not reached, got bin=%0d want 5", e_bin); end
    apply_reset();
    checks++;
    if ({valid_o, bin_o, data_re_o, data_im_o} !== {1'b0, LG'(0), DW'(0), DW'(0)}) begin
      errs++; $display("FAIL rstmid_zero: got v=%b bin=%0d re=%h im=%h, want all zero", valid_o, bin_o, data_re_o, data_im_o);
    end
    for (int n = 0; n < N + 20; n++) begin
      if (n < N) apply(1'b1, bitrev(LG'(n)), DW'($urandom), DW'($urandom));
      else       apply(1'b0, '0, '0, '0);
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL rstmid_post cyc=%0d: got v=%b bin=%0d re=%h im=%h, want v=%b bin=%0d re=%h im=%h",
                         cyc, valid_o, bin_o, data_re_o, data_im_o, e_v, e_bin, e_re, e_im);
      end
    end
  endtask

  task automatic test_extremes();
    int hits = 0;
    logic [LG-1:0] c;
    logic [DW-1:0] re, im;
    for (int n = 0; n < N + 20; n++) begin
      c = bitrev(LG'(n));
      re = DW'($urandom); im = DW'($urandom);
      if (c == 0)      begin re = 25'h1000000; im = 25'h0FFFFFF; end
      if (c == N - 1)  begin re = 25'h0FFFFFF; im = 25'h1000000; end
      if (n < N) apply(1'b1, c, re, im);
      else       apply(1'b0, '0, '0, '0);
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL extremes cyc=%0d: got v=%b bin=%0d re=%h im=%h, want v=%b bin=%0d re=%h im=%h",
                         cyc, valid_o, bin_o, data_re_o, data_im_o, e_v, e_bin, e_re, e_im);
      end
      if (valid_o === 1'b1 && bin_o == 0) begin
        hits++; checks++;
        if (data_re_o !== 25'h1000000 || data_im_o !== 25'h0FFFFFF) begin
          errs++; $display("FAIL extreme_bin0: got re=%h im=%h, want 1000000 0ffffff", data_re_o, data_im_o);
        end
      end
      if (valid_o === 1'b1 && bin_o == N - 1) begin
        hits++; checks++;
        if (data_re_o !== 25'h0FFFFFF || data_im_o !== 25'h1000000) begin
          errs++; $display("FAIL extreme_bin15: got re=%h im=%h, want 0ffffff 1000000", data_re_o, data_im_o);
        end
      end
    end
    checks++;
    if (hits !== 2) begin errs++; $display("FAIL extreme_seen: got %0d extreme bins, want 2", hits); end
  endtask

  task automatic test_idle();
    apply_reset();
    for (int n = 0; n < 100; n++) begin
      apply(1'b0, LG'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {1'b0, LG'(0), DW'(0), DW'(0)}) begin
        errs++; $display("FAIL idle cyc=%0d: got v=%b bin=%0d re=%h im=%h, want all zero", cyc, valid_o, bin_o, data_re_o, data_im_o);
      end
    end
  endtask

  task automatic test_random();
    logic [LG-1:0] perm [N];
    logic [LG-1:0] t;
    int j, k;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) perm[i] = LG'(i);
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0)); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      k = 0;
      while (k < N) begin
        if ($urandom_range(3, 0) == 0) apply(1'b0, '0, '0, '0);
        else begin apply(1'b1, perm[k], DW'($urandom), DW'($urandom)); k++; end
        checks++;
        if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
          errs++; $display("FAIL random cyc=%0d: got v=%b bin=%0d re=%h im=%h, want v=%b bin=%0d re=%h im=%h",
                           cyc, valid_o, bin_o, data_re_o, data_im_o, e_v, e_bin, e_re, e_im);
        end
      end
    end
    for (int n = 0; n < 20; n++) begin
      apply(1'b0, '0, '0, '0);
      checks++;
      if ({valid_o, bin_o, data_re_o, data_im_o} !== {e_v, e_bin, e_re, e_im}) begin
        errs++; $display("FAIL random_tail cyc=%0d: got v=%b bin=%0d re=%h, want v=%b bin=%0d re=%h",
                         cyc, valid_o, bin_o, data_re_o, e_v, e_bin, e_re);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Reorder buffer placed directly downstream of the radix-2^2 SDF FFT. It takes the FFT's bit-reversed-order output stream with its bin index and sync flag, and emits each frame in natural bin order (0..N-1) as a gapless stream. It uses a ping-pong pair of N-deep complex RAM banks: one bank is written while the other is read out.

Parameters:
N, 1024, FFT length; power of 2
N_LOG2, 10, log2(N); width of bin indices and RAM addresses
DATA_WIDTH, 25, signed width of each real/imag sample; equals FFT OUTPUT_WIDTH

Ports:
clk_i  input  1  system clock; same clock as the FFT's clk_i
rst_n  input  1  reset
sync_i  input  1  input sample valid; driven by FFT sync_o
ctr_i  input  N_LOG2  frequency bin index of the current input sample; driven by FFT data_ctr_o
data_re_i  input  DATA_WIDTH  input real part, signed
data_im_i  input  DATA_WIDTH  input imaginary part, signed
valid_o  output  1  output sample valid
bin_o  output  N_LOG2  natural-order bin index of the output sample
data_re_o  output  DATA_WIDTH  output real part, signed
data_im_o  output  DATA_WIDTH  output imaginary part, signed

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk_i. When rst_n=0 at an edge:
  - valid_o=0, bin_o=0, data_re_o=0, data_im_o=0.
  - Write count=0, wr_bank=0, read engine idle, rd_addr=0.
  - RAM contents are not cleared.
  - Reset mid-frame or mid-readout discards all partial state. The first frame after reset starts from write count 0.
- Storage:
  - Two banks, each N x (2*DATA_WIDTH), inferred as synchronous block RAM.
  - Write port on bank wr_bank; read port on bank !wr_bank.
- Write side:
  - On every edge with sync_i=1, {data_re_i,data_im_i} is written to bank[wr_bank] at address ctr_i. ctr_i is already the natural bin index, so no address transform is applied.
  - An internal write count (N_LOG2+1 bits) increments once per written sample.
  - sync_i=0 pauses writing; the count holds and there is no timeout.
  - When a write occurs with count==N-1, all of the following happen on that edge:
    - The frame is complete: count goes to 0 and wr_bank toggles.
    - The read engine is armed on the just-filled bank with rd_addr=0.
- Read-side state machine:
  - IDLE: stays here until a frame completes, then goes to READ.
  - READ: rd_addr increments by 1 each cycle; RAM read is registered.
    - After rd_addr==N-1 is issued, go to IDLE unless another frame completed on that same edge.
    - If another frame completed on that edge, rd_addr wraps to 0 and READ continues on the new bank with no idle cycle.
- Output timing:
  - The output register is loaded one cycle after the RAM read.
  - valid_o first rises on the 2nd rising edge after the edge that wrote the frame's final sample.
  - bin_o then steps 0,1,...,N-1 on consecutive cycles, with data_re_o/data_im_o equal to the sample written at ctr_i==bin_o.
  - Total latency from final-sample write to bin 0 output: 2 cycles.
  - Back-to-back input frames (sync_i held high) give valid_o continuously high with no gap between frames.
- Hazard freedom:
  - With at most one write per cycle, the next frame cannot complete until N cycles after the previous one, so readout of a bank always finishes before that bank is rewritten.
  - After a bank swap, the first write to the old read bank occurs at or after the cycle following its final read address. There is no read/write collision, so no overrun logic exists.
- valid_o=0 cycles: bin_o, data_re_o and data_im_o hold their last values.
- Arithmetic: pure pass-through. No scaling, no sign change; width in equals width out.
- ctr_i ordering: ctr_i values within a frame are a permutation of 0..N-1. Duplicate indices are not detected; the last write wins.

Test Plan:
1. N=16, DATA_WIDTH=25. After reset, drive one frame: sync_i=1 for 16 cycles, ctr_i=bitrev(n), data_re_i=100+ctr_i, data_im_i=-ctr_i. Required: valid_o rises 2 edges after the 16th write; bin_o=0..15 over 16 consecutive cycles; data_re_o=100+bin_o, data_im_o=-bin_o; then valid_o=0.
2. Three back-to-back frames with sync_i held high for 48 cycles, frame f data_re_i=16*f+ctr_i. Required: valid_o high for exactly 48 consecutive cycles; data_re_o=16*f+bin_o; bin_o wraps 15->0 between frames.
3. Gapped frame: 7 samples, then sync_i=0 for 5 cycles, then the remaining 9 samples. Required: no output until 2 edges after the 16th write; all 16 bins correct and in order.
4. Reset asserted for 1 cycle while bin_o=5 of a readout. Required: next edge gives valid_o=0, bin_o=0, data=0. A fresh full frame afterwards outputs correctly starting from bin 0.
5. Extremes: data_re_i=-2^24, data_im_i=2^24-1 at ctr_i=0; data_re_i=2^24-1, data_im_i=-2^24 at ctr_i=15. Required: bit-exact signed values at bin_o=0 and bin_o=15.
6. Idle input: sync_i=0 for 100 cycles after reset. Required: valid_o stays 0 and all outputs stay 0.
